window_line_buffer: RTL and testbench
=====================================

WINDOW_LINE_BUFFER -- requirements
Module: window_line_buffer

Interface
REQ-001 Parameter DATA_W, default 8, pixel width in bits.
REQ-002 Parameter LINE_LEN, default 512, pixels per line; any value >= TAPS, not restricted to powers of two.
REQ-003 Parameter TAPS, default 3, horizontal window width in pixels; range 1..8.
REQ-004 i_clk  in  1  sole clock; all logic on rising edge.
REQ-005 i_rst  in  1  reset; synchronous, active-high.
REQ-006 i_data  in  DATA_W  write pixel.
REQ-007 i_data_valid  in  1  write strobe.
REQ-008 i_rd_data  in  1  read strobe; advances window by one pixel.
REQ-009 o_data  out  TAPS*DATA_W  window; tap 0 (oldest pixel) in the MSBs.
REQ-010 o_data_valid  out  1  o_data holds a window produced by a read.
REQ-011 o_wr_ready  out  1  block accepts writes.
REQ-012 o_line_full  out  1  LINE_LEN pixels stored, read phase active.
REQ-013 o_ovf  out  1  sticky dropped-write flag.

Function
REQ-014 FSM states: FILL (encoding 0) and READ (encoding 1); state FILL after reset.
REQ-015 FILL: o_wr_ready=1 and o_line_full=0; each i_data_valid stores i_data at wr_ptr, and wr_ptr increments by 1.
REQ-016 In FILL, a write at wr_ptr=LINE_LEN-1 wraps wr_ptr to 0 and moves the FSM to READ on the next edge.
REQ-017 READ: o_wr_ready=0 and o_line_full=1.
REQ-018 i_rd_data in READ registers o_data = {pix[r], pix[r+1], ..., pix[r+TAPS-1]} and sets o_data_valid=1 on the next edge (latency 1); r then increments by 1.
REQ-019 Right-edge clamp: a tap index above LINE_LEN-1 reads pix[LINE_LEN-1] (edge replication).
REQ-020 A read at rd_ptr=LINE_LEN-1 wraps rd_ptr to 0 and moves the FSM to FILL on the next edge.
REQ-021 o_data_valid is 0 in any cycle following no accepted read; o_data holds its last value.
REQ-022 i_rd_data in FILL is ignored: no pointer change, o_data_valid=0.
REQ-023 i_data_valid while o_wr_ready=0 (READ, including the final read cycle) is dropped: memory is unchanged and o_ovf sets to 1.
REQ-024 o_ovf stays 1 until reset.
REQ-025 Simultaneous i_data_valid and i_rd_data in READ: the read is performed and the write is dropped per REQ-023.
REQ-026 Pointers are $clog2(LINE_LEN) bits wide.
REQ-027 Wrap compares against LINE_LEN-1, never relies on natural overflow.
REQ-028 Tap address arithmetic uses one extra bit so clamping is exact.

Reset
REQ-029 i_rst takes priority over all inputs, including mid-fill and mid-read.
REQ-030 Reset values: wr_ptr=0, rd_ptr=0, state FILL, o_data=0, o_data_valid=0, o_wr_ready=1, o_line_full=0, o_ovf=0.
REQ-031 Pixel memory is not reset; stale contents are never output, because reads require a complete new fill.

Structure
REQ-032 Shared package window_line_buffer_pkg holds the FSM state encodings (FILL, READ) and the TAPS range limits.
REQ-033 Pixel storage is a sub-module lb_line_ram (one write port, TAPS asynchronous read ports), parametrised by DATA_W and LINE_LEN.
REQ-034 The FSM, pointers, clamp logic and output register are in window_line_buffer; estimated size 150-300 lines of RTL.

Verification (DATA_W=8, LINE_LEN=8, TAPS=3)
REQ-035 Fill: reset, then write 0x10..0x17 on consecutive cycles -> o_line_full=1 and o_wr_ready=0 on the edge after the 8th write.
REQ-036 First read: one i_rd_data pulse -> next cycle o_data=0x101112 and o_data_valid=1; the cycle after, o_data_valid=0 and o_data holds.
REQ-037 Clamp: read 8 windows back-to-back -> 6th window 0x151617, 7th 0x161717, 8th 0x171717; then o_line_full=0 and o_wr_ready=1.
REQ-038 Overflow: in READ, assert i_data_valid with 0xAA -> o_ovf=1 and stays 1; read windows unchanged (first window still 0x101112).
REQ-039 Read ignored: i_rd_data during FILL after 3 writes -> o_data_valid stays 0 and the next complete fill's first window is pix[0..2].
REQ-040 Mid-read reset: after 4 reads assert i_rst -> all outputs at REQ-030 values; refill with 0x20..0x27 -> first window 0x202122.

Source files
------------

// File: rtl/window_line_buffer_pkg.sv
// rtl/window_line_buffer_pkg.sv - shared definitions for the window line buffer
//
// Purpose: FSM state encodings and the legal TAPS range used by
//          window_line_buffer and its line RAM.
// Ports:   none (package).
package window_line_buffer_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_READ = 1'b1
  } lb_state_e;

  localparam int TAPS_MIN = 1;
  localparam int TAPS_MAX = 8;

endpackage

// File: rtl/lb_line_ram.sv
// rtl/lb_line_ram.sv - single-line pixel store, one write port, TAPS async read ports
//
// Purpose: holds one line of LINE_LEN pixels. Contents are never reset; the
//          controller only reads locations written during the current fill.
// Ports:
//   i_clk    - write clock (rising edge)
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write pixel
//   i_raddr  - TAPS packed read addresses, port k in slice k
//   o_rdata  - TAPS packed read pixels, port k in slice k (combinational)
module lb_line_ram
  import window_line_buffer_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 512,
  parameter int TAPS     = 3,
  parameter int ADDR_W   = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [ADDR_W-1:0]        i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [TAPS*ADDR_W-1:0]   i_raddr,
  output logic [TAPS*DATA_W-1:0]   o_rdata
);

  logic [DATA_W-1:0] mem [LINE_LEN];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_rd_port
    assign o_rdata[k*DATA_W +: DATA_W] = mem[i_raddr[k*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/window_line_buffer.sv
// rtl/window_line_buffer.sv - fill-then-read line buffer producing TAPS-wide windows
//
// Purpose: stores one full line of pixels, then lets the consumer step a
//          TAPS-pixel window across it, replicating the last pixel past the
//          right edge. Writes arriving while the line is being read are
//          dropped and flagged in a sticky overflow bit.
// Ports:
//   i_clk         - clock, rising edge
//   i_rst         - synchronous active-high reset
//   i_data        - write pixel
//   i_data_valid  - write strobe
//   i_rd_data     - read strobe, advances the window by one pixel
//   o_data        - window, tap 0 (oldest pixel) in the MSBs
//   o_data_valid  - o_data was produced by a read on the previous edge
//   o_wr_ready    - writes are accepted (fill phase)
//   o_line_full   - a complete line is stored (read phase)
//   o_ovf         - sticky dropped-write flag
module window_line_buffer
  import window_line_buffer_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 512,
  parameter int TAPS     = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_data_valid,
  input  logic                   i_rd_data,
  output logic [TAPS*DATA_W-1:0] o_data,
  output logic                   o_data_valid,
  output logic                   o_wr_ready,
  output logic                   o_line_full,
  output logic                   o_ovf
);

  localparam int PTR_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LINE_LEN - 1);

  lb_state_e              state_q, state_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [TAPS*DATA_W-1:0] data_q, data_d;
  logic                   data_valid_q, data_valid_d;
  logic                   ovf_q, ovf_d;

  logic                   ram_we;
  logic [TAPS*PTR_W-1:0]  ram_raddr;
  logic [TAPS*DATA_W-1:0] ram_rdata;
  logic [TAPS*DATA_W-1:0] window;
  logic [PTR_W:0]         tap_sum [TAPS];

  lb_line_ram #(
    .DATA_W   (DATA_W),
    .LINE_LEN (LINE_LEN),
    .TAPS     (TAPS),
    .ADDR_W   (PTR_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_data),
    .i_raddr (ram_raddr),
    .o_rdata (ram_rdata)
  );

  // Tap addresses carry one extra bit: rd_ptr + t can exceed LINE_LEN-1 by
  // up to TAPS-1, and the compare must see the true sum to clamp exactly.
  always_comb begin
    ram_raddr = '0;
    window    = '0;
    for (int t = 0; t < TAPS; t++) begin
      tap_sum[t] = {1'b0, rd_ptr_q} + (PTR_W+1)'(t);
      if (tap_sum[t] > {1'b0, LAST_PTR}) begin
        ram_raddr[t*PTR_W +: PTR_W] = LAST_PTR;
      end else begin
        ram_raddr[t*PTR_W +: PTR_W] = tap_sum[t][PTR_W-1:0];
      end
      // Port t feeds tap t; tap 0 lands in the MSBs.
      window[(TAPS-1-t)*DATA_W +: DATA_W] = ram_rdata[t*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    ovf_d        = ovf_q;
    ram_we       = 1'b0;
    o_wr_ready   = 1'b0;
    o_line_full  = 1'b0;

    case (state_q)
      ST_FILL: begin
        o_wr_ready = 1'b1;
        if (i_data_valid) begin
          ram_we = 1'b1;
          if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d = '0;
            state_d  = ST_READ;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      ST_READ: begin
        o_line_full = 1'b1;
        if (i_data_valid) begin
          ovf_d = 1'b1;
        end
        if (i_rd_data) begin
          data_d       = window;
          data_valid_d = 1'b1;
          if (rd_ptr_q == LAST_PTR) begin
            rd_ptr_d = '0;
            state_d  = ST_FILL;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_FILL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = data_valid_q;
  assign o_ovf        = ovf_q;

endmodule

// File: tb/tb_window_line_buffer.sv
// tb/tb_window_line_buffer.sv - self-checking bench for window_line_buffer
module tb_window_line_buffer;

  localparam int DATA_W   = 8;
  localparam int LINE_LEN = 8;
  localparam int TAPS     = 3;

  logic                   clk;
  logic                   rst;
  logic [DATA_W-1:0]      din;
  logic                   dv;
  logic                   rd;
  logic [TAPS*DATA_W-1:0] o_data;
  logic                   o_data_valid;
  logic                   o_wr_ready;
  logic                   o_line_full;
  logic                   o_ovf;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  window_line_buffer #(
    .DATA_W   (DATA_W),
    .LINE_LEN (LINE_LEN),
    .TAPS     (TAPS)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data       (din),
    .i_data_valid (dv),
    .i_rd_data    (rd),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_wr_ready   (o_wr_ready),
    .o_line_full  (o_line_full),
    .o_ovf        (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a line is either being collected or being scanned.
  int          m_wr_count;
  int          m_rd_count;
  bit          m_filled;
  logic [7:0]  m_pix [LINE_LEN];
  logic [23:0] m_data;
  bit          m_valid;
  bit          m_ovf;

  always @(posedge clk) begin
    if (rst) begin
      m_wr_count = 0;
      m_rd_count = 0;
      m_filled   = 1'b0;
      m_data     = '0;
      m_valid    = 1'b0;
      m_ovf      = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (!m_filled) begin
        if (dv) begin
          m_pix[m_wr_count] = din;
          m_wr_count++;
          if (m_wr_count == LINE_LEN) begin
            m_wr_count = 0;
            m_filled   = 1'b1;
          end
        end
      end else begin
        if (dv) m_ovf = 1'b1;
        if (rd) begin
          m_data = '0;
          for (int t = 0; t < TAPS; t++) begin
            int idx;
            idx = m_rd_count + t;
            if (idx > LINE_LEN - 1) idx = LINE_LEN - 1;
            m_data = (m_data << 8) | 24'(m_pix[idx]);
          end
          m_valid = 1'b1;
          m_rd_count++;
          if (m_rd_count == LINE_LEN) begin
            m_rd_count = 0;
            m_filled   = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_data_valid", 64'(o_data_valid), 64'(m_valid));
      chk("model_data",       64'(o_data),       64'(m_data));
      chk("model_wr_ready",   64'(o_wr_ready),   64'(!m_filled));
      chk("model_line_full",  64'(o_line_full),  64'(m_filled));
      chk("model_ovf",        64'(o_ovf),        64'(m_ovf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < LINE_LEN; i++) begin
      dv  = 1'b1;
      din = base + 8'(i);
      step();
    end
    dv = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    dv  = 1'b0;
    rd  = 1'b0;
    din = '0;
    step();
    step();
    chk("reset_data",      64'(o_data),       64'h0);
    chk("reset_valid",     64'(o_data_valid), 64'h0);
    chk("reset_wr_ready",  64'(o_wr_ready),   64'h1);
    chk("reset_line_full", 64'(o_line_full),  64'h0);
    chk("reset_ovf",       64'(o_ovf),        64'h0);
    rst = 1'b0;
    check_en = 1'b1;

    // Fill 0x10..0x17; the phase changes only on the edge of the 8th write.
    for (int i = 0; i < LINE_LEN; i++) begin
      dv  = 1'b1;
      din = 8'h10 + 8'(i);
      step();
      if (i == LINE_LEN - 2) chk("fill_7_not_full", 64'(o_line_full), 64'h0);
    end
    dv = 1'b0;
    chk("fill_line_full", 64'(o_line_full), 64'h1);
    chk("fill_wr_ready",  64'(o_wr_ready),  64'h0);

    // Dropped write during READ.
    dv  = 1'b1;
    din = 8'hAA;
    step();
    dv = 1'b0;
    chk("ovf_set", 64'(o_ovf), 64'h1);

    // First window, then hold.
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("first_window", 64'(o_data),       64'h101112);
    chk("first_valid",  64'(o_data_valid), 64'h1);
    step();
    chk("hold_valid",   64'(o_data_valid), 64'h0);
    chk("hold_data",    64'(o_data),       64'h101112);

    // Windows 2..8 back-to-back; window 4 also carries a dropped write.
    for (int k = 2; k <= LINE_LEN; k++) begin
      rd  = 1'b1;
      dv  = (k == 4);
      din = 8'h55;
      step();
      if (k == 4) chk("simul_window4", 64'(o_data), 64'h131415);
      if (k == 6) chk("clamp_window6", 64'(o_data), 64'h151617);
      if (k == 7) chk("clamp_window7", 64'(o_data), 64'h161717);
      if (k == 8) chk("clamp_window8", 64'(o_data), 64'h171717);
    end
    rd = 1'b0;
    dv = 1'b0;
    chk("back_to_fill_line_full", 64'(o_line_full), 64'h0);
    chk("back_to_fill_wr_ready",  64'(o_wr_ready),  64'h1);
    chk("ovf_sticky",             64'(o_ovf),       64'h1);

    // Read strobe during FILL is ignored.
    for (int i = 0; i < 3; i++) begin
      dv  = 1'b1;
      din = 8'h30 + 8'(i);
      step();
    end
    dv = 1'b0;
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("fill_read_ignored", 64'(o_data_valid), 64'h0);
    for (int i = 3; i < LINE_LEN; i++) begin
      dv  = 1'b1;
      din = 8'h30 + 8'(i);
      step();
    end
    dv = 1'b0;
    chk("refill_full", 64'(o_line_full), 64'h1);
    rd = 1'b1;
    step();
    chk("refill_window1", 64'(o_data), 64'h303132);
    step();
    step();
    step();
    rd = 1'b0;
    chk("refill_window4", 64'(o_data), 64'h333435);

    // Reset in the middle of a read phase.
    rst = 1'b1;
    step();
    chk("midreset_data",      64'(o_data),       64'h0);
    chk("midreset_valid",     64'(o_data_valid), 64'h0);
    chk("midreset_wr_ready",  64'(o_wr_ready),   64'h1);
    chk("midreset_line_full", 64'(o_line_full),  64'h0);
    chk("midreset_ovf",       64'(o_ovf),        64'h0);
    rst = 1'b0;

    fill(8'h20);
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("after_reset_window1", 64'(o_data), 64'h202122);
    step();

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
